// File: rtl/control_unit_if.sv
// Datapath-side bundle of the control unit: instruction register in, control strobes out.
// The control unit is the master; the datapath (or a bench) sits on the slave side.
interface control_unit_if;
    logic [31:0] IR;
    logic        PCout, IncPC, PC_enable, MAR_enable;
    logic        MDR_read, MDR_enable, MDRout, IR_enable, RAM_write;
    logic        Gra, Grb, Grc, R_in, R_out, BAout, Cout;
    logic        Y_enable, ZLowIn, ZHighIn, ZLowout;
    logic [4:0]  ALU_op;
    logic        Run;

    modport master (
        input  IR,
        output PCout, IncPC, PC_enable, MAR_enable,
        output MDR_read, MDR_enable, MDRout, IR_enable, RAM_write,
        output Gra, Grb, Grc, R_in, R_out, BAout, Cout,
        output Y_enable, ZLowIn, ZHighIn, ZLowout,
        output ALU_op, Run
    );

    modport slave (
        output IR,
        input  PCout, IncPC, PC_enable, MAR_enable,
        input  MDR_read, MDR_enable, MDRout, IR_enable, RAM_write,
        input  Gra, Grb, Grc, R_in, R_out, BAout, Cout,
        input  Y_enable, ZLowIn, ZHighIn, ZLowout,
        input  ALU_op, Run
    );
endinterface

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch and execute for a simple single-bus CPU datapath.
// Define MEM_WAIT_EN to insert a wait state (W0, W5) ahead of each memory read.
module control_unit (
    input  logic          Clock,
    input  logic          Clear,
    control_unit_if.master dp
);
    localparam logic [4:0] OP_LDW  = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_STW  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef MEM_WAIT_EN
        , S_W0, S_W5
`endif
    } state_e;

    typedef enum logic [2:0] {
        K_LDW, K_LDI, K_STW, K_ALU_REG, K_ALU_IMM, K_NOP, K_HALT
    } kind_e;

    state_e     state_q, state_d;
    kind_e      kind;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = dp.IR[31:27];
    assign unused_ir = ^dp.IR[26:0];

    // Unrecognised opcodes fall through to K_NOP.
    always_comb begin
        kind = K_NOP;
        case (opcode)
            OP_LDW:                          kind = K_LDW;
            OP_LDI:                          kind = K_LDI;
            OP_STW:                          kind = K_STW;
            OP_ADD, OP_SUB, OP_AND, OP_OR:   kind = K_ALU_REG;
            OP_ADDI, OP_ANDI, OP_ORI:        kind = K_ALU_IMM;
            OP_HALT:                         kind = K_HALT;
            default:                         kind = K_NOP;
        endcase
    end

    // NOTE: state register uses non-blocking assignment; async clear forces RESET at once.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path infers a latch.
        state_d       = state_q;
        dp.PCout      = 1'b0;
        dp.IncPC      = 1'b0;
        dp.PC_enable  = 1'b0;
        dp.MAR_enable = 1'b0;
        dp.MDR_read   = 1'b0;
        dp.MDR_enable = 1'b0;
        dp.MDRout     = 1'b0;
        dp.IR_enable  = 1'b0;
        dp.RAM_write  = 1'b0;
        dp.Gra        = 1'b0;
        dp.Grb        = 1'b0;
        dp.Grc        = 1'b0;
        dp.R_in       = 1'b0;
        dp.R_out      = 1'b0;
        dp.BAout      = 1'b0;
        dp.Cout       = 1'b0;
        dp.Y_enable   = 1'b0;
        dp.ZLowIn     = 1'b0;
        dp.ZHighIn    = 1'b0;
        dp.ZLowout    = 1'b0;
        dp.ALU_op     = 5'b00000;
        dp.Run        = (state_q != S_RESET) && (state_q != S_HALT);

        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                dp.PCout      = 1'b1;
                dp.MAR_enable = 1'b1;
                dp.IncPC      = 1'b1;
                dp.MDR_read   = 1'b1;
`ifdef MEM_WAIT_EN
                state_d = S_W0;
`else
                state_d = S_T1;
`endif
            end
`ifdef MEM_WAIT_EN
            S_W0: begin
                dp.MDR_read = 1'b1;
                state_d     = S_T1;
            end
            S_W5: begin
                dp.MDR_read = 1'b1;
                state_d     = S_T6;
            end
`endif
            S_T1: begin
                dp.MDR_read   = 1'b1;
                dp.MDR_enable = 1'b1;
                dp.PC_enable  = 1'b1;
                state_d       = S_T2;
            end
            S_T2: begin
                dp.MDRout    = 1'b1;
                dp.IR_enable = 1'b1;
                state_d      = S_T3;
            end
            S_T3: begin
                case (kind)
                    K_LDI, K_LDW, K_STW: begin
                        dp.Grb      = 1'b1;
                        dp.BAout    = 1'b1;
                        dp.Y_enable = 1'b1;
                        state_d     = S_T4;
                    end
                    K_ALU_REG, K_ALU_IMM: begin
                        dp.Grb      = 1'b1;
                        dp.R_out    = 1'b1;
                        dp.Y_enable = 1'b1;
                        state_d     = S_T4;
                    end
                    K_HALT:  state_d = S_HALT;
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                // Address and immediate forms both add the constant to Y.
                dp.ZLowIn  = 1'b1;
                dp.ZHighIn = 1'b1;
                state_d    = S_T5;
                if (kind == K_ALU_REG) begin
                    dp.Grc    = 1'b1;
                    dp.R_out  = 1'b1;
                    dp.ALU_op = opcode;
                end else if (kind == K_ALU_IMM) begin
                    dp.Cout   = 1'b1;
                    dp.ALU_op = opcode;
                end else begin
                    dp.Cout   = 1'b1;
                    dp.ALU_op = OP_ADD;
                end
            end
            S_T5: begin
                dp.ZLowout = 1'b1;
                if (kind == K_LDW) begin
                    dp.MAR_enable = 1'b1;
`ifdef MEM_WAIT_EN
                    state_d = S_W5;
`else
                    state_d = S_T6;
`endif
                end else if (kind == K_STW) begin
                    dp.MAR_enable = 1'b1;
                    state_d       = S_T6;
                end else begin
                    dp.Gra  = 1'b1;
                    dp.R_in = 1'b1;
                    state_d = S_T0;
                end
            end
            S_T6: begin
                dp.MDR_enable = 1'b1;
                state_d       = S_T7;
                if (kind == K_STW) begin
                    dp.Gra   = 1'b1;
                    dp.R_out = 1'b1;
                end else begin
                    dp.MDR_read = 1'b1;
                end
            end
            S_T7: begin
                state_d = S_T0;
                if (kind == K_STW) begin
                    dp.RAM_write = 1'b1;
                end else begin
                    dp.MDRout = 1'b1;
                    dp.Gra    = 1'b1;
                    dp.R_in   = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end
endmodule
